// File: rtl/shared_mem_responder_pkg.sv
// Shared constants and FSM encoding for the
// shared-memory responder.
package shared_mem_responder_pkg;

  localparam int NUM_CORES_DEF = 8;
  localparam int GID_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: first set
// request after the pointer, wrapping.
module rr_arbiter
  import shared_mem_responder_pkg::*;
#(
  parameter int N = NUM_CORES_DEF
) (
  input  logic [N-1:0]     req_i,
  input  logic [GID_W-1:0] ptr_i,
  output logic [GID_W-1:0] win_o,
  output logic             any_o
);

  // Scan farthest-first so the nearest hit overrides.
  always_comb begin
    int idx;
    idx   = 0;
    win_o = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        win_o = GID_W'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/shared_mem_responder.sv
// Round-robin shared word memory responder:
// one read/write per 3 cycles, one-hot Ack.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [NUM_CORES-1:0]          Req,
  input  logic [NUM_CORES-1:0]          We,
  input  logic [NUM_CORES*ADDR_W-1:0]   Addr,
  input  logic [NUM_CORES*DATA_W-1:0]   WData,
  output logic [NUM_CORES-1:0]          Ack,
  output logic [DATA_W-1:0]             RData,
  output logic                          Busy,
  output logic [GID_W-1:0]              GrantId
);

  state_e                 state_q, state_d;
  logic [GID_W-1:0]       ptr_q, ptr_d;
  logic [GID_W-1:0]       gid_q, gid_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic [DATA_W-1:0]      mem_q [2**ADDR_W];

  logic [GID_W-1:0]       win;
  logic                   any_req;

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_arb (
    .req_i (Req),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gid_d   = win;
          we_d    = We[win];
          addr_d  = Addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = WData[int'(win)*DATA_W +: DATA_W];
          busy_d  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = we_q ? '0 : mem_q[addr_q];
        ack_d   = NUM_CORES'(1) << gid_q;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        busy_d  = 1'b0;
        ptr_d   = gid_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= GID_W'(NUM_CORES - 1);
      gid_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Reset forces IDLE asynchronously, so an aborted write never lands.
  always_ff @(posedge Clk) begin
    if (state_q == ST_ACCESS && we_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign Ack     = ack_q;
  assign RData   = rdata_q;
  assign Busy    = busy_q;
  assign GrantId = gid_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed + randomized bench with a transaction
// level round-robin / memory reference model.
module tb_shared_mem_responder;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  Req;
  logic [7:0]  We;
  logic [63:0] Addr;
  logic [255:0] WData;
  logic [7:0]  Ack;
  logic [31:0] RData;
  logic        Busy;
  logic [2:0]  GrantId;

  shared_mem_responder dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Req     (Req),
    .We      (We),
    .Addr    (Addr),
    .WData   (WData),
    .Ack     (Ack),
    .RData   (RData),
    .Busy    (Busy),
    .GrantId (GrantId)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  req_m;
  logic [7:0]  we_m;
  logic [7:0]  addr_m [8];
  logic [31:0] wd_m [8];
  logic [31:0] mem_m [256];
  int          ptr_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      vectors++;
      assert ($onehot0(Ack) && !(Ack != 8'h00 && Busy !== 1'b1)) else begin
        miscompares++;
        $error("FAIL ack_legal: observed Ack=%h Busy=%b expected onehot0 with Busy",
               Ack, Busy);
      end
    end
  end

  function automatic int rr_pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 8; i++) begin
      Addr[i*8 +: 8]   = addr_m[i];
      WData[i*32 +: 32] = wd_m[i];
    end
    Req = req_m;
    We  = we_m;
  endtask

  task automatic set_op(input int c, input bit w, input logic [7:0] a,
                        input logic [31:0] d);
    we_m[c]   = w;
    addr_m[c] = a;
    wd_m[c]   = d;
  endtask

  // Call only with the DUT idle and requests just driven.
  task automatic run_multi(input int n, input bit cont, input int budget,
                           input int force_first);
    int done = 0;
    int cyc = 0;
    int last_cyc = 0;
    int prev = -1;
    int e;
    while (done < n && cyc < budget) begin
      @(negedge Clk);
      cyc++;
      if (Ack !== 8'h00) begin
        e = rr_pick(req_m, ptr_m);
        if (done == 0 && force_first >= 0) chk("first_winner", e, force_first);
        chk("ack_vec", Ack, 32'(8'h01 << e));
        chk("grant_id", GrantId, e);
        chk("ack_spacing", cyc, done == 0 ? 2 : last_cyc + 3);
        if (prev >= 0 && cont) chk("no_repeat", prev != e, 1);
        if (we_m[e]) begin
          chk("rdata_wr", RData, 0);
          mem_m[addr_m[e]] = wd_m[e];
        end else begin
          chk("rdata_rd", RData, mem_m[addr_m[e]]);
        end
        ptr_m = e;
        prev = e;
        last_cyc = cyc;
        done++;
        if (cont && done < n)
          set_op(e, $urandom_range(0, 1), 8'($urandom), $urandom);
        else
          req_m[e] = 1'b0;
        if (cont && done == n) req_m = 8'h00;
        drive();
      end
    end
    chk("txn_count", done, n);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    req_m = 8'h00;
    drive();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    ptr_m = 7;
    @(negedge Clk);
  endtask

  initial begin
    int c;
    Rst_n = 1'b0;
    req_m = 8'h00;
    we_m  = 8'h00;
    for (int i = 0; i < 8; i++) set_op(i, 1'b0, 8'h00, 32'h0);
    drive();
    ptr_m = 7;

    // 1: reset with random requests
    for (int i = 0; i < 3; i++) begin
      Req = 8'($urandom);
      @(negedge Clk);
      chk("rst_ack", Ack, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_rdata", RData, 0);
      chk("rst_gid", GrantId, 0);
    end
    Req = 8'h00;
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_busy", Busy, 0);
    chk("idle_ack", Ack, 0);

    // 2: core 3 write then read
    req_m = 8'h08;
    set_op(3, 1'b1, 8'h10, 32'hDEADBEEF);
    drive();
    run_multi(1, 1'b0, 10, 3);
    req_m = 8'h08;
    set_op(3, 1'b0, 8'h10, 32'h0);
    drive();
    run_multi(1, 1'b0, 10, 3);
    chk("wr_rd_data", mem_m[8'h10], 32'hDEADBEEF);

    // preload every word through the DUT
    for (int a = 0; a < 256; a++) begin
      c = a % 8;
      req_m = 8'h00;
      req_m[c] = 1'b1;
      set_op(c, 1'b1, 8'(a), $urandom);
      drive();
      run_multi(1, 1'b0, 10, c);
    end

    // 3: all cores after reset, order 0..7
    do_reset();
    for (int i = 0; i < 8; i++) set_op(i, 1'b0, 8'(i * 13 + 5), 32'h0);
    req_m = 8'hFF;
    drive();
    run_multi(8, 1'b0, 40, 0);
    chk("order_ptr_end", ptr_m, 7);

    // 4: cores 2 and 5 continuous
    set_op(2, 1'b0, 8'h21, 32'h0);
    set_op(5, 1'b0, 8'h52, 32'h0);
    req_m = 8'h24;
    drive();
    run_multi(6, 1'b1, 40, 2);

    // 5: reset during ACCESS aborts write
    req_m = 8'h01;
    set_op(0, 1'b1, 8'h20, 32'h11);
    drive();
    run_multi(1, 1'b0, 10, 0);
    req_m = 8'h02;
    set_op(1, 1'b1, 8'h20, 32'h55);
    drive();
    @(negedge Clk);
    chk("mid_busy", Busy, 1);
    chk("mid_ack", Ack, 0);
    Rst_n = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_ack", Ack, 0);
    req_m = 8'h00;
    drive();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    ptr_m = 7;
    @(negedge Clk);
    chk("abort_noack", Ack, 0);
    req_m = 8'h02;
    set_op(1, 1'b0, 8'h20, 32'h0);
    drive();
    run_multi(1, 1'b0, 10, 1);
    chk("abort_mem", mem_m[8'h20], 32'h11);

    // 6: core 6 drops Req right after sampling
    req_m = 8'h40;
    set_op(6, 1'b0, 8'h33, 32'h0);
    drive();
    @(negedge Clk);
    req_m = 8'h00;
    addr_m[6] = 8'h99;
    drive();
    @(negedge Clk);
    chk("drop_ack", Ack, 8'h40);
    chk("drop_gid", GrantId, 6);
    chk("drop_rdata", RData, mem_m[8'h33]);
    @(negedge Clk);
    chk("drop_ack_once", Ack, 0);
    ptr_m = 6;
    @(negedge Clk);

    // random mixes
    for (int r = 0; r < 8; r++) begin
      req_m = 8'($urandom_range(1, 255));
      for (int i = 0; i < 8; i++)
        set_op(i, $urandom_range(0, 1), 8'($urandom), $urandom);
      drive();
      run_multi($countones(req_m), 1'b0, 40, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
